// File: rtl/hash_window_scanner_if.sv
// Bus interface for hash_window_scanner: capture strobe, scroll controls and
// the displayed window.
interface hash_window_scanner_if #(
  parameter int DATA_W = 256,
  parameter int WIN_W  = 16
);
  localparam int NUM_WIN = DATA_W / WIN_W;
  localparam int SEL_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              auto_mode;
  logic [SEL_W-1:0]  sel;
  logic              hold;
  logic [WIN_W-1:0]  window;
  logic [SEL_W-1:0]  win_idx;
  logic              captured;
  logic              sweep_done;

  // Stimulus side: drives capture and scroll controls, observes the window.
  modport master (
    output data_in, data_valid, auto_mode, sel, hold,
    input  window, win_idx, captured, sweep_done
  );

  // Scanner side.
  modport slave (
    input  data_in, data_valid, auto_mode, sel, hold,
    output window, win_idx, captured, sweep_done
  );
endinterface

// File: rtl/hash_window_scanner.sv
// Captures a wide word (e.g. a hash result) and presents it one WIN_W slice
// at a time, either under manual selection or auto-scrolling with a dwell
// time per slice.
module hash_window_scanner #(
  parameter int DATA_W = 256,
  parameter int WIN_W  = 16,
  parameter int DWELL  = 125000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hash_window_scanner_if.slave  bus
);

  localparam int NUM_WIN = DATA_W / WIN_W;
  localparam int SEL_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_WIN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  // Alternating 1010... pattern shown when there is nothing valid to show.
  localparam logic [WIN_W-1:0] PAD      = WIN_W'({(WIN_W + 1) / 2{2'b10}});

  // Parameter sanity: the word must split evenly into windows.
  if ((DATA_W % WIN_W) != 0) begin : g_bad_split
    $error("hash_window_scanner: DATA_W must be a multiple of WIN_W");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("hash_window_scanner: DWELL must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_e;

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic [DATA_W-1:0]               r_snapshot;
  logic [SEL_W-1:0]                r_win_idx;
  logic [CNT_W-1:0]                r_dwell_cnt;
  logic                            r_captured;
  logic                            r_sweep_done;

  logic [SEL_W-1:0]                w_win_idx_nxt;
  logic [CNT_W-1:0]                w_cnt_nxt;
  logic                            w_sweep_nxt;
  logic                            w_wrap;
  logic [NUM_WIN-1:0][WIN_W-1:0]   w_slices;
  logic [WIN_W-1:0]                w_window;

  // Index NUM_WIN-1 and any out-of-range index both wrap back to 0.
  assign w_wrap   = (r_win_idx >= LAST_IDX);
  assign w_slices = r_snapshot;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave EMPTY on the first capture, then follow auto_mode.
  // NOTE: the output is assigned a default before any branch, so every path
  // through the block writes it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (bus.data_valid) begin
          w_state_nxt = bus.auto_mode ? ST_AUTO : ST_MANUAL;
        end
      end
      ST_MANUAL, ST_AUTO: begin
        w_state_nxt = bus.auto_mode ? ST_AUTO : ST_MANUAL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Per-state outputs: next window index, dwell count and wrap pulse.
  always_comb begin
    w_win_idx_nxt = r_win_idx;
    w_cnt_nxt     = r_dwell_cnt;
    w_sweep_nxt   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_cnt_nxt = '0;
        if (bus.data_valid) begin
          w_win_idx_nxt = bus.auto_mode ? '0 : bus.sel;
        end
      end
      ST_MANUAL: begin
        // sel tracks through one register stage; dwell stays parked at 0
        // so a switch to AUTO starts a full dwell on the current index.
        w_win_idx_nxt = bus.sel;
        w_cnt_nxt     = '0;
      end
      ST_AUTO: begin
        if (bus.data_valid) begin
          // A fresh capture restarts the sweep and overrides any advance
          // or wrap due on the same edge.
          w_win_idx_nxt = '0;
          w_cnt_nxt     = '0;
        end else if (!bus.hold) begin
          if (r_dwell_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (w_wrap) begin
              w_win_idx_nxt = '0;
              w_sweep_nxt   = 1'b1;
            end else begin
              w_win_idx_nxt = r_win_idx + SEL_W'(1);
            end
          end else begin
            w_cnt_nxt = r_dwell_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_win_idx_nxt = '0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  // Datapath registers: snapshot, capture flag, scroll position, wrap pulse.
  // NOTE: the snapshot is a plain register, not a memory, and is cleared on
  // reset because its contents reach the window output directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snapshot   <= '0;
      r_captured   <= 1'b0;
      r_win_idx    <= '0;
      r_dwell_cnt  <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      if (bus.data_valid) begin
        r_snapshot <= bus.data_in;
        r_captured <= 1'b1;
      end
      r_win_idx    <= w_win_idx_nxt;
      r_dwell_cnt  <= w_cnt_nxt;
      r_sweep_done <= w_sweep_nxt;
    end
  end

  // Window mux: registered snapshot and index straight to the output, PAD
  // before the first capture or for an index past the last window.
  always_comb begin
    w_window = PAD;
    if (r_captured && (r_win_idx <= LAST_IDX)) begin
      w_window = w_slices[r_win_idx];
    end
  end

  assign bus.window     = w_window;
  assign bus.win_idx    = r_win_idx;
  assign bus.captured   = r_captured;
  assign bus.sweep_done = r_sweep_done;

endmodule

// File: tb/tb_hash_window_scanner.sv
// Directed bench for hash_window_scanner: a 256-bit instance with DWELL=4
// through manual, auto, hold, capture-on-wrap and mid-sweep reset, plus a
// 48-bit instance for the non-power-of-two window count.
module tb_hash_window_scanner;

  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [255:0] word_a;
  logic [255:0] word_b;
  logic [15:0]  exp_a [16];
  logic [15:0]  exp_b [16];

  always #5 clk = ~clk;

  hash_window_scanner_if #(.DATA_W(256), .WIN_W(16)) bus_a ();
  hash_window_scanner_if #(.DATA_W(48),  .WIN_W(16)) bus_b ();

  hash_window_scanner #(.DATA_W(256), .WIN_W(16), .DWELL(DWELL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  hash_window_scanner #(.DATA_W(48), .WIN_W(16), .DWELL(DWELL)) u_dut_48 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    word_a = 256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271;
    word_b = 256'h0000111122223333444455556666777788889999aaaabbbbccccddddeeeeffff;
    exp_a = '{16'h6271, 16'h75a4, 16'h6b61, 16'hffd0, 16'h04c9, 16'h5b31,
              16'h2f9d, 16'h0138, 16'h1e1f, 16'h3c54, 16'hb2ed, 16'h016e,
              16'hf369, 16'h1c98, 16'hb8f1, 16'hd0e8};
    exp_b = '{16'hffff, 16'heeee, 16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa,
              16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444,
              16'h3333, 16'h2222, 16'h1111, 16'h0000};

    rst_n            = 1'b0;
    bus_a.data_in    = '0;
    bus_a.data_valid = 1'b0;
    bus_a.auto_mode  = 1'b0;
    bus_a.sel        = 4'd3;
    bus_a.hold       = 1'b0;
    bus_b.data_in    = '0;
    bus_b.data_valid = 1'b0;
    bus_b.auto_mode  = 1'b0;
    bus_b.sel        = 2'd0;
    bus_b.hold       = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // Reset, nothing captured yet: PAD shown, index parked at 0.
    tick(2);
    check("empty_window",   bus_a.window,     16'haaaa);
    check("empty_captured", bus_a.captured,   1'b0);
    check("empty_win_idx",  bus_a.win_idx,    4'd0);
    check("empty_sweep",    bus_a.sweep_done, 1'b0);

    // First capture in MANUAL with sel=0.
    bus_a.data_in    = word_a;
    bus_a.data_valid = 1'b1;
    bus_a.sel        = 4'd0;
    tick(1);
    bus_a.data_valid = 1'b0;
    check("man_captured", bus_a.captured, 1'b1);
    check("man_sel0_idx", bus_a.win_idx,  4'd0);
    check("man_sel0_win", bus_a.window,   16'h6271);

    // sel=15: window still old slice before the edge, new slice after.
    bus_a.sel = 4'd15;
    #1;
    check("man_sel15_pre", bus_a.window, 16'h6271);
    tick(1);
    check("man_sel15_idx", bus_a.win_idx, 4'd15);
    check("man_sel15_win", bus_a.window,  16'hd0e8);
    bus_a.sel = 4'd7;
    tick(1);
    check("man_sel7_win", bus_a.window, 16'h0138);

    // AUTO from index 0: one index per 4 cycles, wrap after 64 cycles.
    bus_a.sel = 4'd0;
    tick(1);
    bus_a.auto_mode = 1'b1;
    tick(1);
    for (int k = 0; k < 64; k++) begin
      check("auto_idx",   bus_a.win_idx,    32'(k / 4));
      check("auto_win",   bus_a.window,     exp_a[k / 4]);
      check("auto_sweep", bus_a.sweep_done, 1'b0);
      tick(1);
    end
    check("wrap_idx",   bus_a.win_idx,    4'd0);
    check("wrap_sweep", bus_a.sweep_done, 1'b1);
    tick(1);
    check("wrap_sweep_end", bus_a.sweep_done, 1'b0);
    check("wrap_idx_hold0", bus_a.win_idx,    4'd0);

    // Sweep position is now 1 (idx 0, dwell 1); move to idx 5, dwell 2.
    tick(21);
    check("pre_hold_idx", bus_a.win_idx, 4'd5);
    bus_a.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("hold_idx", bus_a.win_idx, 4'd5);
      check("hold_win", bus_a.window,  16'h5b31);
    end
    bus_a.hold = 1'b0;
    tick(1);
    check("resume_idx_a", bus_a.win_idx, 4'd5);
    tick(1);
    check("resume_idx_b", bus_a.win_idx, 4'd6);
    check("resume_win_b", bus_a.window,  16'h2f9d);

    // Run to idx 15, dwell 3 and capture on the wrapping edge.
    tick(39);
    check("pre_cap_idx", bus_a.win_idx, 4'd15);
    bus_a.data_in    = word_b;
    bus_a.data_valid = 1'b1;
    tick(1);
    bus_a.data_valid = 1'b0;
    check("capwrap_idx",   bus_a.win_idx,    4'd0);
    check("capwrap_sweep", bus_a.sweep_done, 1'b0);
    check("capwrap_win",   bus_a.window,     16'hffff);
    tick(1);
    check("capwrap_sweep_next", bus_a.sweep_done, 1'b0);
    check("capwrap_idx_next",   bus_a.win_idx,    4'd0);
    tick(3);
    check("newword_idx1", bus_a.window, 16'heeee);

    // Advance to idx 9, then reset mid-sweep with competing controls.
    tick(32);
    check("pre_rst_idx", bus_a.win_idx, 4'd9);
    check("pre_rst_win", bus_a.window,  16'h6666);
    rst_n            = 1'b0;
    bus_a.data_valid = 1'b1;
    bus_a.hold       = 1'b1;
    tick(1);
    check("rst_captured", bus_a.captured,   1'b0);
    check("rst_idx",      bus_a.win_idx,    4'd0);
    check("rst_win",      bus_a.window,     16'haaaa);
    check("rst_sweep",    bus_a.sweep_done, 1'b0);
    bus_a.data_valid = 1'b0;
    bus_a.hold       = 1'b0;
    bus_a.auto_mode  = 1'b0;
    rst_n            = 1'b1;
    tick(2);
    check("post_rst_captured", bus_a.captured, 1'b0);
    check("post_rst_win",      bus_a.window,   16'haaaa);

    // 48-bit word: three windows, sel=3 is past the end and reads PAD.
    bus_b.data_in    = 48'h333322221111;
    bus_b.data_valid = 1'b1;
    bus_b.sel        = 2'd3;
    tick(1);
    bus_b.data_valid = 1'b0;
    check("w48_captured", bus_b.captured, 1'b1);
    check("w48_sel3_idx", bus_b.win_idx,  2'd3);
    check("w48_sel3_win", bus_b.window,   16'haaaa);
    bus_b.sel = 2'd2;
    tick(1);
    check("w48_sel2_win", bus_b.window, 16'h3333);
    bus_b.sel = 2'd0;
    tick(1);
    check("w48_sel0_win", bus_b.window, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hash_window_scanner.md
HASH_WINDOW_SCANNER -- requirements
Module: hash_window_scanner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, width of captured word.
REQ-002 The block SHALL have parameter WIN_W, default 16, width of one display window; DATA_W SHALL be a multiple of WIN_W (elaboration error otherwise).
REQ-003 The block SHALL have parameter DWELL, default 125000000, clock cycles each window is shown in auto mode; DWELL >= 1.
REQ-004 The block SHALL derive NUM_WIN = DATA_W/WIN_W and SEL_W = max(1, clog2(NUM_WIN)).
REQ-005 The block SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n input 1, reset, synchronous and active-low.
REQ-007 The block SHALL have port data_in input DATA_W, word to capture, e.g. a hash result.
REQ-008 The block SHALL have port data_valid input 1, capture strobe, sampled each cycle.
REQ-009 The block SHALL have port auto_mode input 1, 0 = manual select, 1 = auto scroll.
REQ-010 The block SHALL have port sel input SEL_W, manual window index.
REQ-011 The block SHALL have port hold input 1, pauses auto scroll while high.
REQ-012 The block SHALL have port window output WIN_W, selected slice of the captured word.
REQ-013 The block SHALL have port win_idx output SEL_W, index of the slice on window.
REQ-014 The block SHALL have port captured output 1, high once a word has been captured.
REQ-015 The block SHALL have port sweep_done output 1, one-cycle pulse when auto scroll wraps.

Function
REQ-016 The block SHALL latch data_in into a DATA_W snapshot register on any edge with data_valid=1; otherwise the snapshot holds.
REQ-017 The block SHALL set captured on the first capture edge and keep it set until reset.
REQ-018 The block SHALL drive window = snapshot[win_idx*WIN_W +: WIN_W] combinationally from registered snapshot and win_idx (0-cycle output latency).
REQ-019 The block SHALL drive window = PAD ({WIN_W/2{2'b10}}, 16'hAAAA at default) while captured=0, or when win_idx >= NUM_WIN.
REQ-020 The block SHALL run a state machine with states EMPTY (no capture yet), MANUAL and AUTO; EMPTY -> MANUAL/AUTO on first capture per auto_mode; MANUAL <-> AUTO follows auto_mode each cycle once captured=1.
REQ-021 The block SHALL in MANUAL register win_idx <= sel every cycle (1-cycle latency from sel to window); the dwell counter is held at 0.
REQ-022 The block SHALL in AUTO increment a dwell counter each cycle with hold=0; when the counter reaches DWELL-1 it resets to 0 and win_idx advances by 1.
REQ-023 The block SHALL wrap win_idx from NUM_WIN-1 to 0 in AUTO and assert sweep_done for exactly that cycle after the wrapping edge.
REQ-024 The block SHALL freeze both dwell counter and win_idx while hold=1 in AUTO; hold has no effect in MANUAL or EMPTY.
REQ-025 The block SHALL, on a capture edge in AUTO, set win_idx=0 and dwell counter=0, with capture taking priority over a simultaneous advance or wrap (no sweep_done that cycle).
REQ-026 The block SHALL, on a capture edge in MANUAL, keep win_idx = sel (new data visible same index next cycle).
REQ-027 The block SHALL, on MANUAL -> AUTO, start scrolling from current win_idx with dwell counter 0; on AUTO -> MANUAL, win_idx takes sel on the next edge.
REQ-028 The block SHALL accept sel >= NUM_WIN (non-power-of-2 NUM_WIN) in MANUAL and output PAD for it.
REQ-029 The block SHALL treat DWELL=1 as advancing win_idx every cycle in AUTO with hold=0.

Reset
REQ-030 The block SHALL, on rising clk with rst_n=0, clear snapshot to 0, win_idx to 0, dwell counter to 0, captured to 0, sweep_done to 0, and enter EMPTY; window then reads PAD.
REQ-031 The block SHALL give reset priority over data_valid, hold and mode on the same edge, including mid-sweep.

Verification (DATA_W=256, WIN_W=16, DWELL=4 unless noted)
REQ-032 The bench SHALL check reset then no capture, sel=3 -> window=16'hAAAA, captured=0, win_idx=0.
REQ-033 The bench SHALL check capture of 256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271 in MANUAL, sel=0 -> 16'h6271; sel=15 -> 16'hd0e8 one cycle after sel changes.
REQ-034 The bench SHALL check AUTO with the same word, hold=0 -> win_idx advances every 4 cycles 0..15, and sweep_done pulses once at 15->0 (64 cycles per sweep).
REQ-035 The bench SHALL check hold=1 for 10 cycles at win_idx=5 -> win_idx and window unchanged, then resumes with remaining dwell count.
REQ-036 The bench SHALL check data_valid on the same edge as the 15->0 wrap -> new snapshot, win_idx=0, sweep_done stays 0.
REQ-037 The bench SHALL check rst_n=0 mid-sweep at win_idx=9 -> next cycle captured=0, win_idx=0, window=16'hAAAA; also run with DATA_W=48 and sel=3 -> PAD.
